exec_stage: RTL
===============

Name: exec_stage

Overview:
- Execute stage of the 5-stage pipeline. Takes decoded operands and control from the decode/execute register and computes the ALU result or store data.
- Owns the execute→memory pipeline register consumed by the memory stage: alu_result, wsel, wdat_source, dmemREN, dmemWEN, dmemstore, halt, instr_npc.
- Single-cycle ALU ops, plus an iterative multi-cycle MUL that stalls upstream.
- Honours the memory stage's data_stall back-pressure.

Parameters:
- MUL_STEP, 2, multiplier bits retired per cycle. Must divide 32. Iteration count N = 32/MUL_STEP.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  decode/execute register holds a real instruction.
- in_aluop  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SLT, 9 SLTU, 10 LUI, 11 MUL; 12-15 treated as ADD.
- in_rdat1, in_rdat2, in_imm  input  32 each  register operands and sign/zero-extended immediate.
- in_alusrc  input  1  1 = operand B is in_imm, else in_rdat2.
- in_shamt  input  5  shift amount.
- in_wsel  input  5  destination register; 0 = no write.
- in_wdat_source  input  2  write-back source select; passed through.
- in_dmemREN, in_dmemWEN, in_halt  input  1 each  passed through.
- in_instr_npc  input  32  passed through.
- in_ovf_chk  input  1  instruction is a trapping ADD/SUB.
- flush  input  1  kill instruction in execute (branch/jump resolved).
- data_stall  input  1  memory stage busy; hold output register.
- ex_stall  output  1  upstream must hold the decode/execute register.
- out_alu_result, out_dmemstore, out_instr_npc  output  32 each  pipeline register.
- out_wsel  output  5  pipeline register.
- out_wdat_source  output  2  pipeline register.
- out_dmemREN, out_dmemWEN, out_halt  output  1 each  pipeline register.
- out_ovf  output  1  signed overflow flag (optional feature).

Behaviour:
- Reset (RST=1 at edge): all out_* = 0, FSM = IDLE, multiplier datapath cleared; ex_stall = 0 during and after reset. Reset mid-MUL aborts it.
- Operand B = in_alusrc ? in_imm : in_rdat2.
- ALU ops:
  - ADD/SUB wrap modulo 2^32.
  - SLT is signed, SLTU is unsigned; result is 0 or 1.
  - SLL/SRL shift B by in_shamt, logical.
  - LUI = {in_imm[15:0], 16'h0}.
- out_dmemstore <= in_rdat2 (never the immediate).
- Load enable = !data_stall && !ex_stall. On load: if in_valid && !flush, capture the instruction's fields; otherwise load a bubble (all out_* = 0).
- data_stall=1: every out_* holds its value exactly.
- Latency: single-cycle ops appear on out_* on the edge after presentation.
- MUL FSM:
  - IDLE: in_valid && op==MUL && !flush → BUSY, counter = 0. ex_stall=1 combinationally in that same cycle.
  - BUSY: shift-add retires MUL_STEP bits per cycle. After N cycles → DONE. ex_stall=1 throughout.
  - DONE: ex_stall=0; result = low 32 bits of the unsigned product. Loads when !data_stall, then → IDLE. If data_stall, stay DONE with result held.
  - Total: MUL occupies N+1 cycles before the output register can load.
- flush: in any FSM state, → IDLE same edge and the partial product is discarded. The next load is a bubble. If data_stall is also 1, out_* hold and the killed instruction never reaches out_*.
- Back-to-back MUL: the FSM returns to IDLE on the edge upstream presents the next instruction. A new MUL starts the following cycle with no duplicate execution.

Optional Feature:
- Macro EXEC_OVERFLOW_TRAP_EN.
- Defined: ADD/SUB with in_ovf_chk=1 and signed overflow loads out_ovf=1 and out_wsel=0, suppressing write-back. All other fields load normally.
- Undefined: out_ovf is constant 0 and no overflow logic is present.

Test Plan:
- RST=1 for 2 cycles → all out_*=0, ex_stall=0. First post-reset ADD 5+7 → out_alu_result=12 one edge later.
- SLT 0xFFFFFFFF vs 1 → 1. SLTU same operands → 0. SLL 1 by 31 → 0x80000000. LUI imm 0x1234 → 0x12340000.
- MUL 0x0001_0003 × 0x0000_0005, MUL_STEP=2 → ex_stall high 16 cycles, result 0x0005_000F loaded on cycle 17.
- LW presented while data_stall=1 for 3 cycles → out_* unchanged for 3 edges. LW fields load on the first edge with data_stall=0.
- flush during cycle 5 of a MUL → ex_stall drops next cycle, out_* bubble (wsel=0, REN=WEN=0), no MUL result ever appears.
- With EXEC_OVERFLOW_TRAP_EN: ADD 0x7FFFFFFF+1 with in_ovf_chk=1 → out_ovf=1, out_wsel=0. Same op with in_ovf_chk=0 → out_alu_result=0x80000000, out_ovf=0.

Source files
------------

// File: rtl/exec_stage.sv
// exec_stage: execute stage with single-cycle ALU, iterative shift-add MUL and the EX/MEM register.
// Define EXEC_OVERFLOW_TRAP_EN to trap signed overflow on checked ADD/SUB.
module exec_stage #(
  parameter int MUL_STEP = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [3:0]  in_aluop,
  input  logic [31:0] in_rdat1,
  input  logic [31:0] in_rdat2,
  input  logic [31:0] in_imm,
  input  logic        in_alusrc,
  input  logic [4:0]  in_shamt,
  input  logic [4:0]  in_wsel,
  input  logic [1:0]  in_wdat_source,
  input  logic        in_dmemREN,
  input  logic        in_dmemWEN,
  input  logic        in_halt,
  input  logic [31:0] in_instr_npc,
  input  logic        in_ovf_chk,
  input  logic        flush,
  input  logic        data_stall,
  output logic        ex_stall,
  output logic [31:0] out_alu_result,
  output logic [31:0] out_dmemstore,
  output logic [31:0] out_instr_npc,
  output logic [4:0]  out_wsel,
  output logic [1:0]  out_wdat_source,
  output logic        out_dmemREN,
  output logic        out_dmemWEN,
  output logic        out_halt,
  output logic        out_ovf
);
  localparam int N = 32 / MUL_STEP;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 2);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] b, alu, res, mcand, mplier, acc, m_a, m_b, m_acc, prod;
  logic [4:0] wsel_eff;
  logic kill, live, start, ld;
  assign b = in_alusrc ? in_imm : in_rdat2;
  // kill remembers a flush that could not load its bubble, so whatever is presented next is dropped
  assign live = in_valid && !flush && !kill;
  assign start = state == IDLE && live && in_aluop == 4'd11;
  assign ex_stall = !RST && (start || state == BUSY);
  assign ld = !data_stall && !ex_stall;
  // the IDLE cycle retires the first MUL_STEP bits straight from the operands
  assign m_a = state == IDLE ? in_rdat1 : mcand;
  assign m_b = state == IDLE ? b : mplier;
  assign m_acc = state == IDLE ? '0 : acc;
  assign prod = m_acc + m_a * 32'(m_b[MUL_STEP-1:0]);
  assign res = state == DONE ? acc : alu;
  always_comb begin
    case (in_aluop)
      4'd1:    alu = in_rdat1 - b;
      4'd2:    alu = in_rdat1 & b;
      4'd3:    alu = in_rdat1 | b;
      4'd4:    alu = in_rdat1 ^ b;
      4'd5:    alu = ~(in_rdat1 | b);
      4'd6:    alu = b << in_shamt;
      4'd7:    alu = b >> in_shamt;
      4'd8:    alu = {31'b0, $signed(in_rdat1) < $signed(b)};
      4'd9:    alu = {31'b0, in_rdat1 < b};
      4'd10:   alu = {in_imm[15:0], 16'h0};
      default: alu = in_rdat1 + b;
    endcase
  end
`ifdef EXEC_OVERFLOW_TRAP_EN
  logic is_add, is_sub, ovf;
  assign is_add = in_aluop == 4'd0 || in_aluop >= 4'd12;
  assign is_sub = in_aluop == 4'd1;
  assign ovf = in_ovf_chk && (is_add || is_sub) && ((in_rdat1[31] ^ b[31]) == is_sub) && (alu[31] != in_rdat1[31]);
  assign wsel_eff = ovf ? 5'd0 : in_wsel;
  always_ff @(posedge CLK) begin
    if (RST) out_ovf <= 1'b0;
    else if (ld) out_ovf <= live && ovf;
  end
`else
  assign wsel_eff = in_wsel;
  assign out_ovf = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      kill <= 1'b0;
      out_alu_result <= '0;
      out_dmemstore <= '0;
      out_instr_npc <= '0;
      out_wsel <= '0;
      out_wdat_source <= '0;
      out_dmemREN <= 1'b0;
      out_dmemWEN <= 1'b0;
      out_halt <= 1'b0;
    end else begin
      kill <= flush ? !ld : kill && !ld;
      if (flush) begin
        state <= IDLE;
        acc <= '0;
      end else if (start || state == BUSY) begin
        mcand <= m_a << MUL_STEP;
        mplier <= m_b >> MUL_STEP;
        acc <= prod;
        cnt <= start ? '0 : cnt + CW'(1);
        state <= (start ? N == 1 : cnt == LAST) ? DONE : BUSY;
      end else if (state == DONE && !data_stall) state <= IDLE;
      if (ld) begin
        out_alu_result <= live ? res : '0;
        out_dmemstore <= live ? in_rdat2 : '0;
        out_instr_npc <= live ? in_instr_npc : '0;
        out_wsel <= live ? wsel_eff : '0;
        out_wdat_source <= live ? in_wdat_source : '0;
        out_dmemREN <= live && in_dmemREN;
        out_dmemWEN <= live && in_dmemWEN;
        out_halt <= live && in_halt;
      end
    end
  end
endmodule
